rs_slot_alloc: RTL and testbench
================================

Name: rs_slot_alloc

Overview:
- Tracks busy/free state of the N reservation-station entries.
- Each cycle, hands up to two free entry indices to dispatch: the lowest free entry and the highest free entry.
- Picks use the priority selector (ps) from both ends of the free vector.
- Sits between dispatch and the RS entry array. Issue/complete logic returns entries through a release mask.

Parameters:
- NUM_ENTRIES, 16, number of RS entries; must be a power of 2 and at least 4.
- IDX_W, $clog2(NUM_ENTRIES), width of an entry index.
- CNT_W, $clog2(NUM_ENTRIES+1), width of the free counter.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous squash of all entries (branch mispredict).
- alloc_req  input  2  dispatch slot requests; bit0 = older instruction.
- alloc_gnt  output  2  combinational grant per slot.
- alloc_idx0  output  IDX_W  index for slot 0 (lowest free entry).
- alloc_idx1  output  IDX_W  index for slot 1 (highest free entry).
- release_mask  input  NUM_ENTRIES  multi-hot set of entries freed this cycle.
- busy  output  NUM_ENTRIES  registered busy vector.
- free_cnt  output  CNT_W  registered count of free entries.
- full  output  1  registered; high when free_cnt == 0.

Behaviour:
- Reset (reset high at an edge): busy = 0, free_cnt = NUM_ENTRIES, full = 0. Reset has priority over everything.
- Free vector: free_vec = ~busy. Selections are made from registered state only; entries released this cycle are not allocatable until the next cycle.
- Low pick: ps over free_vec gives a one-hot low pick; encode it to alloc_idx0.
- High pick: ps over bit-reversed free_vec gives the high pick; reverse the grant back and encode it to alloc_idx1.
- Grant rules:
  - alloc_gnt[0] = alloc_req[0] & (free_cnt >= 1) & ~flush.
  - alloc_gnt[1] = alloc_req[1] & alloc_req[0] & (free_cnt >= 2) & ~flush.
  - A request on bit1 without bit0 is ignored; slot grants are in order.
- With free_cnt == 1: the low and high picks are the same entry, and only slot 0 may be granted.
- When a slot's grant is 0, its alloc_idx is don't-care and the bench must not check it.
- Busy update at the edge, when not reset and not flush: busy_next = (busy & ~release_mask) | onehot(gnt0 pick) | onehot(gnt1 pick).
- Release of a non-busy entry: ignored, no counter effect.
- An entry cannot be both granted and released in the same cycle, because grants come only from free entries.
- Counter update: free_cnt_next = free_cnt - (gnt0 + gnt1) + popcount(release_mask & busy).
  - Arithmetic is CNT_W wide, with no wrap.
  - Assertion: free_cnt == NUM_ENTRIES - popcount(busy) at all times.
- full_next = (free_cnt_next == 0).
- Flush (not reset): busy = 0, free_cnt = NUM_ENTRIES, full = 0 at the edge. Releases and requests in the flush cycle are discarded, and grants are forced low.
- Latency:
  - Grant and index are combinational with the request, in the same cycle.
  - busy, free_cnt and full reflect the change one cycle later.

Decomposition:
- Shared package rs_pkg:
  - NUM_RS (16) and RS_IDX_W.
  - DISPATCH_WIDTH (2).
  - typedef rs_idx_t.
- Sub-module: reuse the existing priority selector ps, instantiated twice (normal and bit-reversed input) with en tied high.
- One-hot-to-index encoding and popcount are local functions in rs_slot_alloc; no further sub-modules.

Test Plan:
- Reset, then alloc_req=2'b11 → gnt=11, idx0=0, idx1=15. Next cycle: busy=16'h8001, free_cnt=14, full=0.
- Fill: alloc_req=11 for 8 consecutive cycles → busy=16'hFFFF, free_cnt=0, full=1. The ninth request gives gnt=00.
- Single free entry: busy=16'hFFEF, alloc_req=11 → gnt=01, idx0=4. Next cycle: full=1, free_cnt=0.
- Simultaneous alloc and release:
  - Setup: busy=16'h00FF, release_mask=16'h0003, alloc_req=01.
  - Same cycle: idx0=8 (bits 0–1 not yet free).
  - Next cycle: busy=16'h01FC, free_cnt=9.
- Invalid inputs:
  - release_mask=16'hFF00 with busy=16'h00FF → no change, free_cnt stays 8.
  - alloc_req=10 → gnt=00.
- Flush mid-fill: busy=16'h0F0F, flush=1 with alloc_req=11 and release_mask=16'h0001 → gnt=00. Next cycle: busy=0, free_cnt=16. The invariant assertion holds throughout.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared reservation-station constants and types used by dispatch-side logic.
package rs_pkg;

   localparam int NUM_RS         = 16;
   localparam int RS_IDX_W       = $clog2(NUM_RS);
   localparam int DISPATCH_WIDTH = 2;

   typedef logic [RS_IDX_W-1:0] rs_idx_t;

endpackage : rs_pkg

// File: rtl/ps.sv
// Priority selector: one-hot grant of the lowest set request bit, gated by en_i.
module ps #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] req_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] gnt_o
);

   // Isolate the lowest set bit (two's complement trick), then gate with enable.
   always_comb begin
      gnt_o = req_i & (~req_i + WIDTH'(1)) & {WIDTH{en_i}};
   end

endmodule : ps

// File: rtl/rs_slot_alloc.sv
// Reservation-station slot allocator: tracks busy entries and hands dispatch
// the lowest and highest free entry each cycle. Picks come from registered
// state only, so entries released this cycle become allocatable next cycle.
module rs_slot_alloc
   import rs_pkg::*;
#(
   parameter int NUM_ENTRIES = NUM_RS,
   parameter int IDX_W       = $clog2(NUM_ENTRIES),
   parameter int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      flush,
   input  logic [DISPATCH_WIDTH-1:0] alloc_req,
   output logic [DISPATCH_WIDTH-1:0] alloc_gnt,
   output logic [IDX_W-1:0]          alloc_idx0,
   output logic [IDX_W-1:0]          alloc_idx1,
   input  logic [NUM_ENTRIES-1:0]    release_mask,
   output logic [NUM_ENTRIES-1:0]    busy,
   output logic [CNT_W-1:0]          free_cnt,
   output logic                      full
);

   logic [NUM_ENTRIES-1:0] busy_q, busy_d;
   logic [CNT_W-1:0]       free_cnt_q, free_cnt_d;
   logic                   full_q, full_d;

   logic [NUM_ENTRIES-1:0] free_vec;
   logic [NUM_ENTRIES-1:0] free_rev;
   logic [NUM_ENTRIES-1:0] lo_onehot;
   logic [NUM_ENTRIES-1:0] hi_onehot_rev;
   logic [NUM_ENTRIES-1:0] hi_onehot;
   logic                   gnt0, gnt1;

   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_ENTRIES-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (oh[i]) idx = idx | IDX_W'(i);
      end
      return idx;
   endfunction

   function automatic logic [CNT_W-1:0] popcount(input logic [NUM_ENTRIES-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         c = c + CNT_W'(v[i]);
      end
      return c;
   endfunction

   // Free vector and its bit-reversed copy feeding the high-end selector.
   always_comb begin
      free_vec = ~busy_q;
      free_rev = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         free_rev[i] = free_vec[NUM_ENTRIES-1-i];
      end
   end

   ps #(.WIDTH(NUM_ENTRIES)) u_ps_lo (
      .req_i (free_vec),
      .en_i  (1'b1),
      .gnt_o (lo_onehot)
   );

   ps #(.WIDTH(NUM_ENTRIES)) u_ps_hi (
      .req_i (free_rev),
      .en_i  (1'b1),
      .gnt_o (hi_onehot_rev)
   );

   // Undo the reversal so the high pick is in natural bit order.
   always_comb begin
      hi_onehot = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         hi_onehot[i] = hi_onehot_rev[NUM_ENTRIES-1-i];
      end
   end

   // In-order grants: slot 1 needs slot 0 requested and two free entries.
   always_comb begin
      gnt0       = alloc_req[0] & (free_cnt_q >= CNT_W'(1)) & ~flush;
      gnt1       = alloc_req[1] & alloc_req[0] & (free_cnt_q >= CNT_W'(2)) & ~flush;
      alloc_gnt  = {gnt1, gnt0};
      alloc_idx0 = onehot_to_idx(lo_onehot);
      alloc_idx1 = onehot_to_idx(hi_onehot);
   end

   // Next busy/count/full; releases of idle entries are masked out of the count.
   always_comb begin
      busy_d     = (busy_q & ~release_mask)
                 | (gnt0 ? lo_onehot : '0)
                 | (gnt1 ? hi_onehot : '0);
      free_cnt_d = free_cnt_q - CNT_W'(gnt0) - CNT_W'(gnt1)
                 + popcount(release_mask & busy_q);
      full_d     = (free_cnt_d == '0);
   end

   // State register: reset beats flush, flush squashes every entry.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         busy_q     <= '0;
         free_cnt_q <= CNT_W'(NUM_ENTRIES);
         full_q     <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         free_cnt_q <= free_cnt_d;
         full_q     <= full_d;
      end
   end

   assign busy     = busy_q;
   assign free_cnt = free_cnt_q;
   assign full     = full_q;

endmodule : rs_slot_alloc

// File: tb/tb_rs_slot_alloc.sv
// Self-checking bench for rs_slot_alloc: directed scenarios plus random traffic
// against a free-list model built from plain loops over an entry array.
module tb_rs_slot_alloc;

   logic        clock;
   logic        reset;
   logic        flush;
   logic [1:0]  alloc_req;
   logic [1:0]  alloc_gnt;
   logic [3:0]  alloc_idx0;
   logic [3:0]  alloc_idx1;
   logic [15:0] release_mask;
   logic [15:0] busy;
   logic [4:0]  free_cnt;
   logic        full;

   int n_cmp = 0;
   int n_err = 0;

   // Model: which entries are occupied.
   bit m_busy [16];

   rs_slot_alloc dut (
      .clock        (clock),
      .reset        (reset),
      .flush        (flush),
      .alloc_req    (alloc_req),
      .alloc_gnt    (alloc_gnt),
      .alloc_idx0   (alloc_idx0),
      .alloc_idx1   (alloc_idx1),
      .release_mask (release_mask),
      .busy         (busy),
      .free_cnt     (free_cnt),
      .full         (full)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model_vec();
      logic [15:0] v;
      for (int i = 0; i < 16; i++) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic check_state();
      int nb;
      nb = 0;
      for (int i = 0; i < 16; i++) if (m_busy[i]) nb++;
      chk("busy", busy, model_vec());
      chk("free_cnt", free_cnt, 16 - nb);
      chk("full", full, (nb == 16));
      chk("invariant", free_cnt, 16 - $countones(busy));
   endtask

   // One cycle: drive inputs, check combinational grant, clock, check state.
   task automatic step(input logic [1:0] req, input logic [15:0] rel, input logic fl);
      int nfree, lo, hi;
      logic [1:0] eg;
      alloc_req = req;
      release_mask = rel;
      flush = fl;
      #1;
      nfree = 0; lo = -1; hi = -1;
      for (int i = 0; i < 16; i++) begin
         if (!m_busy[i]) begin
            nfree++;
            if (lo < 0) lo = i;
            hi = i;
         end
      end
      eg[0] = req[0] && (nfree >= 1) && !fl;
      eg[1] = req[1] && req[0] && (nfree >= 2) && !fl;
      chk("gnt", alloc_gnt, eg);
      if (eg[0]) chk("idx0", alloc_idx0, lo);
      if (eg[1]) chk("idx1", alloc_idx1, hi);
      @(posedge clock);
      if (fl) begin
         for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
      end else begin
         for (int i = 0; i < 16; i++) if (rel[i]) m_busy[i] = 1'b0;
         if (eg[0]) m_busy[lo] = 1'b1;
         if (eg[1]) m_busy[hi] = 1'b1;
      end
      #1;
      alloc_req = 2'b00;
      release_mask = '0;
      flush = 1'b0;
      check_state();
   endtask

   task automatic do_reset(input logic [1:0] req);
      reset = 1'b1;
      alloc_req = req;
      release_mask = 16'($urandom);
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b0;
      alloc_req = 2'b00;
      release_mask = '0;
      for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
      chk("rst_busy", busy, 16'h0000);
      chk("rst_free_cnt", free_cnt, 5'd16);
      chk("rst_full", full, 1'b0);
   endtask

   task automatic fill_to(input logic [15:0] target);
      step(2'b00, 16'h0000, 1'b1);
      for (int k = 0; k < 8; k++) step(2'b11, 16'h0000, 1'b0);
      step(2'b00, ~target, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      alloc_req = 2'b00;
      release_mask = '0;
      do_reset(2'b00);

      // First dual allocation from empty.
      step(2'b11, 16'h0000, 1'b0);
      chk("tp_first_busy", busy, 16'h8001);
      chk("tp_first_cnt", free_cnt, 5'd14);

      // Fill completely, then one more request must be refused.
      for (int k = 0; k < 7; k++) step(2'b11, 16'h0000, 1'b0);
      chk("tp_fill_busy", busy, 16'hFFFF);
      chk("tp_fill_full", full, 1'b1);
      step(2'b11, 16'h0000, 1'b0);

      // Single free entry: only slot 0 granted.
      step(2'b00, 16'h0010, 1'b0);
      chk("tp_single_busy", busy, 16'hFFEF);
      step(2'b11, 16'h0000, 1'b0);
      chk("tp_single_full", full, 1'b1);

      // Alloc and release in the same cycle.
      step(2'b00, 16'h0000, 1'b1);
      for (int k = 0; k < 8; k++) step(2'b01, 16'h0000, 1'b0);
      chk("tp_setup_busy", busy, 16'h00FF);
      step(2'b01, 16'h0003, 1'b0);
      chk("tp_same_busy", busy, 16'h01FC);
      chk("tp_same_cnt", free_cnt, 5'd9);

      // Release of idle entries and a lone slot-1 request.
      step(2'b00, 16'h0000, 1'b1);
      for (int k = 0; k < 8; k++) step(2'b01, 16'h0000, 1'b0);
      step(2'b00, 16'hFF00, 1'b0);
      chk("tp_idle_rel_cnt", free_cnt, 5'd8);
      step(2'b10, 16'h0000, 1'b0);

      // Flush mid-fill discards requests and releases.
      fill_to(16'h0F0F);
      chk("tp_flush_setup", busy, 16'h0F0F);
      step(2'b11, 16'h0001, 1'b1);
      chk("tp_flush_busy", busy, 16'h0000);
      chk("tp_flush_cnt", free_cnt, 5'd16);

      // Random traffic.
      for (int k = 0; k < 400; k++) begin
         step(2'($urandom_range(0, 3)),
              16'($urandom & $urandom),
              ($urandom_range(0, 40) == 0));
      end

      // Reset wins over pending requests.
      fill_to(16'h3C3C);
      do_reset(2'b11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_rs_slot_alloc
